// File: rtl/kernel_pr_start_token_issuer.sv
// Producer-side start controller: launches the local process core and writes one
// all-ones start token per invocation into the downstream start FIFO.
module kernel_pr_start_token_issuer #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic                  ap_continue,
  output logic                  proc_start,
  input  logic                  proc_done,
  input  logic                  start_full_n,
  output logic                  start_write,
  output logic [DATA_WIDTH-1:0] start_din,
  output logic [CNT_WIDTH-1:0]  invoke_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StDone} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] invoke_cnt_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic                 launch;

  // The token write, core launch and ap_start acknowledge are one strobe, gated by
  // FIFO space so a full FIFO is never written.
  assign launch = (state_q == StLaunch) && start_full_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      invoke_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ap_start) state_q <= StLaunch;
        end
        StLaunch: begin
          if (start_full_n) begin
            invoke_cnt_q <= invoke_cnt_q + 1'b1;
            state_q      <= StRun;
          end else if (stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (proc_done) state_q <= StDone;
        end
        StDone: begin
          // Back-to-back invocation skips the idle cycle.
          if (ap_continue) state_q <= ap_start ? StLaunch : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_write = launch;
  assign proc_start  = launch;
  assign ap_ready    = launch;
  assign ap_idle     = (state_q == StIdle);
  assign ap_done     = (state_q == StDone);
  assign start_din   = {DATA_WIDTH{1'b1}};
  assign invoke_cnt  = invoke_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_kernel_pr_start_token_issuer.sv
// Scoreboard bench for kernel_pr_start_token_issuer, built with 4-bit counters so
// wrap and saturation are reachable.
module tb_kernel_pr_start_token_issuer;

  localparam int unsigned DW = 1;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ap_start, ap_ready, ap_idle, ap_done, ap_continue;
  logic          proc_start, proc_done, start_full_n, start_write;
  logic [DW-1:0] start_din;
  logic [CW-1:0] invoke_cnt, stall_cnt;

  kernel_pr_start_token_issuer #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .proc_start  (proc_start),
    .proc_done   (proc_done),
    .start_full_n(start_full_n),
    .start_write (start_write),
    .start_din   (start_din),
    .invoke_cnt  (invoke_cnt),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Counter values expected on the cycle a launch strobe appears (pre-increment).
  typedef struct packed {
    logic [CW-1:0] inv;
    logic [CW-1:0] stall;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_pulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every launch strobe must match a queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && (start_write || proc_start || ap_ready)) begin
      exp_t e;
      n_pulse++;
      chk("start_write", 32'(start_write), 32'd1);
      chk("proc_start", 32'(proc_start), 32'd1);
      chk("ap_ready", 32'(ap_ready), 32'd1);
      chk("write_when_full", 32'(start_full_n), 32'd1);
      chk("start_din", 32'(start_din), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("strobe_invoke_cnt", 32'(invoke_cnt), 32'(e.inv));
        chk("strobe_stall_cnt", 32'(stall_cnt), 32'(e.stall));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    ap_start     = 1'b0;
    ap_continue  = 1'b0;
    proc_done    = 1'b0;
    start_full_n = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // From LAUNCH with FIFO space: finish the invocation; next_start selects back-to-back.
  task automatic run_one(input logic [CW-1:0] inv, input logic next_start);
    sb.push_back('{inv: inv, stall: '0});
    chk("launch_not_idle", 32'(ap_idle), 32'd0);
    ap_start = 1'b0;
    tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("done_asserted", 32'(ap_done), 32'd1);
    ap_continue = 1'b1;
    ap_start    = next_start;
    tick();
    ap_continue = 1'b0;
    ap_start    = 1'b0;
  endtask

  initial begin
    int p0;

    // Reset then idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("rst_idle", 32'(ap_idle), 32'd1);
      chk("rst_done", 32'(ap_done), 32'd0);
      chk("rst_invoke", 32'(invoke_cnt), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      tick();
    end

    // Single invocation with fixed timeline
    ap_start = 1'b1;                       // cycle 0
    sb.push_back('{inv: 4'd0, stall: 4'd0});
    tick();                                // cycle 1: strobe
    ap_start = 1'b0;
    chk("single_launch_idle", 32'(ap_idle), 32'd0);
    tick();                                // cycle 2
    tick();                                // cycle 3
    tick();                                // cycle 4
    chk("single_no_early_done", 32'(ap_done), 32'd0);
    proc_done = 1'b1;
    tick();                                // cycle 5
    proc_done = 1'b0;
    chk("single_done_c5", 32'(ap_done), 32'd1);
    tick();                                // cycle 6
    chk("single_done_held", 32'(ap_done), 32'd1);
    tick();                                // cycle 7
    ap_continue = 1'b1;
    tick();                                // cycle 8
    ap_continue = 1'b0;
    chk("single_idle_c8", 32'(ap_idle), 32'd1);
    chk("single_done_clr", 32'(ap_done), 32'd0);
    chk("single_invoke", 32'(invoke_cnt), 32'd1);

    // Backpressure
    do_reset();
    start_full_n = 1'b0;
    ap_start     = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    tick();
    tick();
    chk("bp_stall", 32'(stall_cnt), 32'd3);
    chk("bp_no_launch", 32'(invoke_cnt), 32'd0);
    p0 = n_pulse;
    start_full_n = 1'b1;
    sb.push_back('{inv: 4'd0, stall: 4'd3});
    tick();
    chk("bp_invoke", 32'(invoke_cnt), 32'd1);
    chk("bp_one_pulse", 32'(n_pulse - p0), 32'd1);
    proc_done = 1'b1;
    tick();
    proc_done   = 1'b0;
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;

    // Back-to-back x4
    do_reset();
    p0       = n_pulse;
    ap_start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) run_one(CW'(i), i < 3);
    chk("b2b_pulses", 32'(n_pulse - p0), 32'd4);
    chk("b2b_invoke", 32'(invoke_cnt), 32'd4);
    chk("b2b_idle_end", 32'(ap_idle), 32'd1);

    // Reset coincident with proc_done in RUN
    do_reset();
    ap_start = 1'b1;
    sb.push_back('{inv: 4'd0, stall: 4'd0});
    tick();
    ap_start = 1'b0;
    tick();
    tick();
    reset     = 1'b1;
    proc_done = 1'b1;
    tick();
    reset     = 1'b0;
    proc_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midrun_idle", 32'(ap_idle), 32'd1);
      chk("midrun_no_done", 32'(ap_done), 32'd0);
      chk("midrun_invoke", 32'(invoke_cnt), 32'd0);
      tick();
    end

    // Invocation counter wrap
    do_reset();
    p0       = n_pulse;
    ap_start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) run_one(CW'(i), i < 15);
    chk("wrap_pulses", 32'(n_pulse - p0), 32'd16);
    chk("wrap_invoke", 32'(invoke_cnt), 32'd0);

    // Stall counter saturation
    do_reset();
    start_full_n = 1'b0;
    ap_start     = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    start_full_n = 1'b1;
    sb.push_back('{inv: 4'd0, stall: 4'd15});
    tick();
    chk("sat_invoke", 32'(invoke_cnt), 32'd1);
    chk("sat_stall_hold", 32'(stall_cnt), 32'd15);
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
